// File: rtl/traffic_light_controller_if.sv
// Sensor inputs and lamp outputs of the two-road intersection controller.
// The controller is the slave. The environment drives the sensors as the master.
interface traffic_light_controller_if;
    logic [1:0] EWCar;
    logic [1:0] NSCar;
    logic [1:0] EWLite;
    logic [1:0] NSLite;

    modport master (
        output EWCar,
        output NSCar,
        input  EWLite,
        input  NSLite
    );

    modport slave (
        input  EWCar,
        input  NSCar,
        output EWLite,
        output NSLite
    );
endinterface

// File: rtl/traffic_light_controller.sv
// Two-road intersection controller: a Moore FSM with a min/max green timer,
// fixed yellow and all-red dwells, and lamps decoded from the state register only.
module traffic_light_controller #(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 16,
    parameter int YELLOW    = 2,
    parameter int ALL_RED   = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    traffic_light_controller_if.slave    tl
);
    localparam int M_GREEN = (MIN_GREEN > MAX_GREEN) ? MIN_GREEN : MAX_GREEN;
    localparam int M_CLEAR = (YELLOW > ALL_RED) ? YELLOW : ALL_RED;
    localparam int P_MAX   = (M_GREEN > M_CLEAR) ? M_GREEN : M_CLEAR;
    localparam int TW      = $clog2(P_MAX) + 1;

    // Saturation point is MAX_GREEN-1 for sane parameters. It still lets a long
    // yellow or all-red dwell reach its exit count.
    localparam logic [TW-1:0] T_MIN = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] T_MAX = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] T_YEL = TW'(YELLOW - 1);
    localparam logic [TW-1:0] T_RED = TW'(ALL_RED - 1);
    localparam logic [TW-1:0] T_SAT = TW'(P_MAX - 1);

    localparam logic [1:0] LAMP_RED    = 2'b00;
    localparam logic [1:0] LAMP_YELLOW = 2'b01;
    localparam logic [1:0] LAMP_GREEN  = 2'b10;

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        RED_TO_EW = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        RED_TO_NS = 3'd5
    } state_t;

    state_t          state_reg, state_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic            ew_req, ns_req;
    logic [1:0]      ns_lite, ew_lite;

    assign ew_req = |tl.EWCar;
    assign ns_req = |tl.NSCar;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= NS_GREEN;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
        end
    end

    always_comb begin
        state_next = NS_GREEN;
        timer_next = '0;
        case (state_reg)
            NS_GREEN:  state_next = (timer_reg >= T_MIN && ew_req &&
                                     (!ns_req || timer_reg >= T_MAX)) ? NS_YELLOW : NS_GREEN;
            NS_YELLOW: state_next = (timer_reg >= T_YEL) ? RED_TO_EW : NS_YELLOW;
            RED_TO_EW: state_next = (timer_reg >= T_RED) ? EW_GREEN  : RED_TO_EW;
            EW_GREEN:  state_next = (timer_reg >= T_MIN && ns_req &&
                                     (!ew_req || timer_reg >= T_MAX)) ? EW_YELLOW : EW_GREEN;
            EW_YELLOW: state_next = (timer_reg >= T_YEL) ? RED_TO_NS : EW_YELLOW;
            RED_TO_NS: state_next = (timer_reg >= T_RED) ? NS_GREEN  : RED_TO_NS;
            default:   state_next = NS_GREEN;
        endcase
        // The timer restarts on every state change and otherwise saturates.
        if (state_next != state_reg) begin
            timer_next = '0;
        end else if (timer_reg >= T_SAT) begin
            timer_next = timer_reg;
        end else begin
            timer_next = timer_reg + TW'(1);
        end
    end

    always_comb begin
        ns_lite = LAMP_RED;
        ew_lite = LAMP_RED;
        case (state_reg)
            NS_GREEN:  ns_lite = LAMP_GREEN;
            NS_YELLOW: ns_lite = LAMP_YELLOW;
            EW_GREEN:  ew_lite = LAMP_GREEN;
            EW_YELLOW: ew_lite = LAMP_YELLOW;
            default:   ;
        endcase
    end

    assign tl.NSLite = ns_lite;
    assign tl.EWLite = ew_lite;
endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: a hand-derived vector table, directed
// multi-cycle sequences and a random run checked against a phase/elapsed model.
module tb_traffic_light_controller;
    localparam int MIN_GREEN = 4;
    localparam int MAX_GREEN = 16;
    localparam int YELLOW    = 2;
    localparam int ALL_RED   = 1;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    traffic_light_controller_if tl_if();

    traffic_light_controller #(
        .MIN_GREEN (MIN_GREEN),
        .MAX_GREEN (MAX_GREEN),
        .YELLOW    (YELLOW),
        .ALL_RED   (ALL_RED)
    ) dut (
        .clock (clock),
        .reset (reset),
        .tl    (tl_if)
    );

    typedef struct {
        logic       r;
        logic [1:0] ew;
        logic [1:0] ns;
        logic [1:0] exp_ns;
        logic [1:0] exp_ew;
    } vec_t;

    typedef struct {
        logic [1:0] ns;
        logic [1:0] ew;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: road (0=NS, 1=EW), phase (0=green, 1=yellow, 2=all-red),
    // and an unbounded count of cycles elapsed in the phase.
    int m_road  = 0;
    int m_phase = 0;
    int m_el    = 0;

    function automatic void model_edge(input logic r, input logic [1:0] ew, input logic [1:0] ns);
        logic xr, yr;
        if (r) begin
            m_road = 0; m_phase = 0; m_el = 0;
        end else begin
            case (m_phase)
                0: begin
                    xr = (m_road == 0) ? (|ns) : (|ew);
                    yr = (m_road == 0) ? (|ew) : (|ns);
                    if (m_el >= MIN_GREEN - 1 && yr && (!xr || m_el >= MAX_GREEN - 1)) begin
                        m_phase = 1; m_el = 0;
                    end else m_el++;
                end
                1: if (m_el >= YELLOW - 1) begin m_phase = 2; m_el = 0; end else m_el++;
                default: if (m_el >= ALL_RED - 1) begin
                    m_phase = 0; m_road = 1 - m_road; m_el = 0;
                end else m_el++;
            endcase
        end
    endfunction

    function automatic exp_t model_lamps();
        exp_t e;
        logic [1:0] lamp;
        lamp = (m_phase == 0) ? 2'b10 : (m_phase == 1) ? 2'b01 : 2'b00;
        e.ns = (m_road == 0) ? lamp : 2'b00;
        e.ew = (m_road == 1) ? lamp : 2'b00;
        return e;
    endfunction

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d (0b%0b) want %0d (0b%0b) at %0t", name, got, got, want, want, $time);
        end
    endtask

    // One clock edge: push the expected lamps, drive sensors, compare after the edge.
    task automatic apply(input logic r, input logic [1:0] ew, input logic [1:0] ns,
                         input bit use_tab, input logic [1:0] tns, input logic [1:0] tew,
                         input string name);
        exp_t e;
        model_edge(r, ew, ns);
        if (use_tab) begin
            e.ns = tns; e.ew = tew;
        end else begin
            e = model_lamps();
        end
        sb_q.push_back(e);
        reset = r; tl_if.EWCar = ew; tl_if.NSCar = ns;
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            check({name, ".queue_empty"}, 1, 0);
        end else begin
            e = sb_q.pop_front();
            check({name, ".ns"}, int'(tl_if.NSLite), int'(e.ns));
            check({name, ".ew"}, int'(tl_if.EWLite), int'(e.ew));
        end
        $display("cycle r=%0b ew=%b ns=%b -> NSLite=%b EWLite=%b", r, ew, ns, tl_if.NSLite, tl_if.EWLite);
    endtask

    vec_t tab[23];

    initial begin
        int         cnt;
        logic [3:0] prev_pair, cur_pair;
        int         run;
        bit         first_run;
        logic [1:0] rew, rns;

        reset = 1'b1; tl_if.EWCar = 2'b00; tl_if.NSCar = 2'b00;

        tab[0]  = '{1'b1, 2'b00, 2'b00, 2'b10, 2'b00};
        tab[1]  = '{1'b1, 2'b00, 2'b00, 2'b10, 2'b00};
        tab[2]  = '{1'b0, 2'b01, 2'b00, 2'b10, 2'b00};
        tab[3]  = '{1'b0, 2'b01, 2'b00, 2'b10, 2'b00};
        tab[4]  = '{1'b0, 2'b01, 2'b00, 2'b10, 2'b00};
        tab[5]  = '{1'b0, 2'b01, 2'b00, 2'b01, 2'b00};
        tab[6]  = '{1'b0, 2'b00, 2'b00, 2'b01, 2'b00};
        tab[7]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
        tab[8]  = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b10};
        tab[9]  = '{1'b0, 2'b10, 2'b00, 2'b00, 2'b10};
        tab[10] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b10};
        tab[11] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b10};
        tab[12] = '{1'b0, 2'b11, 2'b00, 2'b00, 2'b10};
        tab[13] = '{1'b0, 2'b11, 2'b01, 2'b00, 2'b10};
        tab[14] = '{1'b0, 2'b00, 2'b01, 2'b00, 2'b01};
        tab[15] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b01};
        tab[16] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
        tab[17] = '{1'b0, 2'b00, 2'b00, 2'b10, 2'b00};
        tab[18] = '{1'b0, 2'b10, 2'b00, 2'b10, 2'b00};
        tab[19] = '{1'b0, 2'b00, 2'b00, 2'b10, 2'b00};
        tab[20] = '{1'b0, 2'b00, 2'b00, 2'b10, 2'b00};
        tab[21] = '{1'b0, 2'b00, 2'b00, 2'b10, 2'b00};
        tab[22] = '{1'b0, 2'b01, 2'b00, 2'b01, 2'b00};

        for (int i = 0; i < 23; i++) begin
            apply(tab[i].r, tab[i].ew, tab[i].ns, 1'b1, tab[i].exp_ns, tab[i].exp_ew,
                  $sformatf("tab%0d", i));
        end

        // Idle after reset: NS stays green indefinitely.
        apply(1'b1, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, "idle_rst");
        apply(1'b1, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, "idle_rst");
        for (int i = 0; i < 50; i++) begin
            apply(1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 2'b00, "idle");
        end

        // Both roads requesting: each green lasts exactly MAX_GREEN cycles.
        apply(1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, "both_rst");
        apply(1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, "both_rst");
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            apply(1'b0, 2'b01, 2'b01, 1'b0, 2'b00, 2'b00, "both");
            if (tl_if.NSLite == 2'b10) cnt++; else break;
        end
        check("ns_max_green_len", cnt, MAX_GREEN);
        for (int i = 0; i < 10 && tl_if.EWLite != 2'b10; i++) begin
            apply(1'b0, 2'b01, 2'b01, 1'b0, 2'b00, 2'b00, "both_clear");
        end
        cnt = (tl_if.EWLite == 2'b10) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            apply(1'b0, 2'b01, 2'b01, 1'b0, 2'b00, 2'b00, "both");
            if (tl_if.EWLite == 2'b10) cnt++; else break;
        end
        check("ew_max_green_len", cnt, MAX_GREEN);

        // Reset asserted for one edge during EW_YELLOW.
        apply(1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, "mid_rst_pre");
        for (int i = 0; i < 40; i++) begin
            if (m_phase == 1 && m_road == 1) break;
            if (m_road == 0) apply(1'b0, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, "to_ew_yellow");
            else             apply(1'b0, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, "to_ew_yellow");
        end
        check("pre_rst_ew_yellow", int'(tl_if.EWLite), 1);
        apply(1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, "mid_rst");
        check("mid_rst_timer", int'(dut.timer_reg), 0);
        apply(1'b0, 2'b00, 2'b01, 1'b0, 2'b00, 2'b00, "after_mid_rst");

        // Random sensors with safety and dwell checks.
        rew = 2'b00; rns = 2'b00;
        prev_pair = {tl_if.NSLite, tl_if.EWLite};
        run = 1; first_run = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 7) == 0) rew = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) rns = 2'($urandom_range(0, 3));
            apply(1'b0, rew, rns, 1'b0, 2'b00, 2'b00, "rand");
            cur_pair = {tl_if.NSLite, tl_if.EWLite};
            check("rand_one_red", int'(cur_pair[3:2] == 2'b00 || cur_pair[1:0] == 2'b00), 1);
            check("rand_ns_via_yellow", int'(prev_pair[3:2] == 2'b10 && cur_pair[3:2] == 2'b00), 0);
            check("rand_ew_via_yellow", int'(prev_pair[1:0] == 2'b10 && cur_pair[1:0] == 2'b00), 0);
            if (cur_pair == prev_pair) begin
                run++;
            end else begin
                if (!first_run && (prev_pair[3:2] == 2'b01 || prev_pair[1:0] == 2'b01))
                    check("rand_yellow_len", run, YELLOW);
                if (!first_run && prev_pair == 4'b0000)
                    check("rand_allred_len", run, ALL_RED);
                first_run = 1'b0;
                run = 1;
            end
            prev_pair = cur_pair;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
